// File: rtl/constraint_sampler_pkg.sv
// ============================================================================
// constraint_sampler_pkg : shared types, constants and helpers for the sampler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package constraint_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FILL       = 3'd1,
    ST_CHECK      = 3'd2,
    ST_WAIT_SPACE = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  localparam int          XS_SH1       = 13;
  localparam int          XS_SH2       = 17;
  localparam int          XS_SH3       = 5;
  localparam logic [31:0] DEFAULT_SEED = 32'h1;

  function automatic int calc_words(input int vec_w, input int word_w);
    return (vec_w + word_w - 1) / word_w;
  endfunction

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_SH1);
    y = y ^ (y >> XS_SH2);
    y = y ^ (y << XS_SH3);
    return y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/constraint_sampler_tx_if.sv
// ============================================================================
// constraint_sampler_tx_if : checker (candidate/sat) and result-stream bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface constraint_sampler_tx_if #(
  parameter int VEC_W = 205
);

  logic [VEC_W-1:0] cand_o;
  logic             cand_valid_o;
  logic             sat_i;
  logic [VEC_W-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;

  // master: the sampler; slave: checker plus result sink
  modport master (
    output cand_o, cand_valid_o, out_data_o, out_valid_o,
    input  sat_i, out_ready_i
  );

  modport slave (
    input  cand_o, cand_valid_o, out_data_o, out_valid_o,
    output sat_i, out_ready_i
  );

endinterface

`default_nettype wire

// File: rtl/constraint_sampler_tx_fifo.sv
// ============================================================================
// sampler_fifo : synchronous FIFO with simultaneous push/pop, even when full
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sampler_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the same-cycle push writes into, so full+pop accepts a push
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/constraint_sampler_tx.sv
// ============================================================================
// constraint_sampler_tx : xorshift candidate generator feeding a constraint
//                         checker; satisfying vectors are queued and streamed
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module constraint_sampler_tx
  import constraint_sampler_pkg::*;
#(
  parameter int VEC_W      = 205,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start_i,
  input  wire logic [31:0]      seed_i,
  input  wire logic [CNT_W-1:0] num_i,
  input  wire logic [CNT_W-1:0] max_attempts_i,
  constraint_sampler_tx_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  exhausted_o,
  output logic      [CNT_W-1:0] attempts_o,
  output logic      [CNT_W-1:0] solutions_o
);

  localparam int             WORDS    = calc_words(VEC_W, WORD_W);
  localparam int             IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [31:0]      xs_q, xs_d;
  logic [VEC_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] att_q, att_d;
  logic [CNT_W-1:0] sol_q, sol_d;
  logic             exh_q, exh_d;

  logic [31:0]      xs_next;
  logic [WORD_W-1:0] gen_word;
  logic [VEC_W-1:0] cand_fill;
  logic             push;
  logic             pop;
  logic             resolve;
  logic             fifo_full;
  logic             fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign xs_next  = xorshift32(xs_q);
  assign gen_word = WORD_W'(xs_next);

  // Slice j of the candidate takes the fresh word only in fill cycle j; the
  // last slice is narrower when VEC_W is not a multiple of WORD_W
  for (genvar j = 0; j < WORDS; j++) begin : g_word
    localparam int LO = j * WORD_W;
    localparam int HI = (((LO + WORD_W) < VEC_W) ? (LO + WORD_W) : VEC_W) - 1;
    assign cand_fill[HI:LO] = (fill_idx_q == IDX_W'(j)) ? gen_word[HI-LO:0]
                                                        : cand_q[HI:LO];
  end

  assign pop = bus.out_valid_o && bus.out_ready_i;

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    xs_d       = xs_q;
    cand_d     = cand_q;
    num_d      = num_q;
    cap_d      = cap_q;
    att_d      = att_q;
    sol_d      = sol_q;
    exh_d      = exh_q;
    push       = 1'b0;
    resolve    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          num_d      = num_i;
          cap_d      = max_attempts_i;
          att_d      = '0;
          sol_d      = '0;
          exh_d      = 1'b0;
          xs_d       = (seed_i == 32'h0) ? DEFAULT_SEED : seed_i;
          fill_idx_d = '0;
          state_d    = (num_i == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        xs_d   = xs_next;
        cand_d = cand_fill;
        if (fill_idx_q == LAST_IDX) begin
          fill_idx_d = '0;
          state_d    = ST_CHECK;
        end else begin
          fill_idx_d = fill_idx_q + 1'b1;
        end
      end
      ST_CHECK: begin
        att_d = sat_inc(att_q);
        if (bus.sat_i && fifo_full && !pop) begin
          state_d = ST_WAIT_SPACE;
        end else begin
          if (bus.sat_i) begin
            push  = 1'b1;
            sol_d = sat_inc(sol_q);
          end
          resolve = 1'b1;
        end
      end
      ST_WAIT_SPACE: begin
        if (!fifo_full || pop) begin
          push    = 1'b1;
          sol_d   = sat_inc(sol_q);
          resolve = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Solutions win over the cap so a satisfying final attempt is not "exhausted"
    if (resolve) begin
      if (sol_d == num_q) begin
        state_d = ST_DONE;
      end else if ((cap_q != '0) && (att_d == cap_q)) begin
        state_d = ST_DONE;
        exh_d   = 1'b1;
      end else begin
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fill_idx_q <= '0;
      xs_q       <= DEFAULT_SEED;
      cand_q     <= '0;
      num_q      <= '0;
      cap_q      <= '0;
      att_q      <= '0;
      sol_q      <= '0;
      exh_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      xs_q       <= xs_d;
      cand_q     <= cand_d;
      num_q      <= num_d;
      cap_q      <= cap_d;
      att_q      <= att_d;
      sol_q      <= sol_d;
      exh_q      <= exh_d;
    end
  end

  sampler_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (cand_q),
    .pop_i   (pop),
    .data_o  (bus.out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.out_valid_o  = !fifo_empty;
  assign bus.cand_o       = cand_q;
  assign bus.cand_valid_o = (state_q == ST_CHECK);
  assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o           = (state_q == ST_DONE);
  assign exhausted_o      = exh_q;
  assign attempts_o       = att_q;
  assign solutions_o      = sol_q;

endmodule

`default_nettype wire
